regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 SHALL have parameter DATA_W, default 18, meaning the register data width in bits.
REQ-002 SHALL have parameter ADDR_W, default 4, meaning the register index width; there are 2**ADDR_W architectural indices.
REQ-003 SHALL have parameter BYPASS, default 1, meaning write-to-read forwarding is enabled when 1.
REQ-004 SHALL have port clk, input, 1, the single clock; all state updates occur on its rising edge.
REQ-005 SHALL have port reset_n, input, 1, the reset; it is asynchronous and active-low.
REQ-006 SHALL have ports ra1 and ra2, input, ADDR_W each, the read addresses.
REQ-007 SHALL have ports we3 (input, 1), wa3 (input, ADDR_W) and wd3 (input, DATA_W), the write-back enable, address and data.
REQ-008 SHALL have port r15, input, DATA_W, the externally supplied value for top index (2**ADDR_W-1).
REQ-009 SHALL have ports iss_en (input, 1) and iss_wa (input, ADDR_W), the issue request and its destination.
REQ-010 SHALL have port flush, input, 1, which clears the scoreboard.
REQ-011 SHALL have ports rd1 and rd2, output, DATA_W each, the read data.
REQ-012 SHALL have ports rd1_busy and rd2_busy, output, 1 each, set when the source has a pending producer.
REQ-013 SHALL have port stall, output, 1, the issue-blocked flag.
REQ-014 SHALL have port busy_cnt, output, ADDR_W+1, the number of busy registers.

Function
REQ-015 SHALL store 2**ADDR_W-1 registers; top index has no storage, and writes to it are ignored.
REQ-016 SHALL drive rdN as follows: raN==top gives r15; otherwise, if BYPASS=1 and we3 and wa3==raN, gives wd3; otherwise gives the stored value.
REQ-017 SHALL write wd3 to register wa3 at the rising edge when we3=1; reads are combinational with zero latency.
REQ-018 SHALL keep one busy bit per stored register; top index is never busy.
REQ-019 SHALL set busy[iss_wa] at the edge when iss_en=1 and stall=0; a stalled issue changes no state.
REQ-020 SHALL clear busy[wa3] at the edge when we3=1.
REQ-021 SHALL give set priority when issue and write-back target the same index in one cycle, so the bit ends busy.
REQ-022 SHALL drive rdN_busy = busy[raN], masked to 0 when BYPASS=1 and we3 and wa3==raN.
REQ-023 SHALL drive stall = iss_en AND (rd1_busy OR rd2_busy OR busy[iss_wa] (WAW)); it is combinational.
REQ-024 SHALL clear all busy bits at the edge when flush=1, overriding same-cycle issue; register contents are unaffected and a same-cycle write still completes.
REQ-025 SHALL hold busy_cnt as a registered population count of the busy bits, consistent with them every cycle (0 to 2**ADDR_W-1, no wrap).

Reset
REQ-026 SHALL, while reset_n=0, immediately clear all registers and busy bits to 0, regardless of clk.
REQ-027 SHALL hold the following values during reset: rd1/rd2 = 0 unless addressing top (then r15) or bypassing; rdN_busy=0; stall=0; busy_cnt=0.
REQ-028 SHALL abandon any write or issue in progress when reset asserts mid-cycle, leaving no partial update.
REQ-029 SHALL accept the first write/issue at the first rising edge after reset_n deasserts.

Structure
REQ-030 SHALL take DATA_W/ADDR_W defaults, the top-index constant function and a reg_idx_t typedef from shared package regfile_pkg.
REQ-031 SHALL implement the busy vector, its update and busy_cnt in one sub-module, regfile_scoreboard; storage and read muxing stay in regfile_sb.

Verification
REQ-032 SHALL verify reset/read: reset_n=0 mid-run, then ra1=3, ra2=15, r15=0x00ABC -> rd1=0, rd2=0x00ABC, busy_cnt=0.
REQ-033 SHALL verify write/bypass: we3=1, wa3=5, wd3=0x12345, ra1=5 in the same cycle -> rd1=0x12345 that cycle (BYPASS=1) and after the edge; with BYPASS=0 the old value is returned that cycle.
REQ-034 SHALL verify issue/RAW: issue wa=7; next cycle iss_en with ra1=7 -> rd1_busy=1, stall=1, busy_cnt stays 1; write-back wa3=7 -> stall=0 that cycle.
REQ-035 SHALL verify same-index set/clear: iss_wa=4 and we3/wa3=4 in the same cycle -> busy[4]=1 afterwards; WAW issue to 4 stalls.
REQ-036 SHALL verify flush: issue to 1, 2, 3 (busy_cnt=3), then flush together with iss_en wa=6 -> busy_cnt=0 and register 6 not busy.
REQ-037 SHALL verify top index: we3=1, wa3=15, wd3=0x3FFFF -> no stored change, rd with ra=15 still returns r15, issue to 15 never stalls.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the scoreboarded register file.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 18;
  localparam int unsigned ADDR_W_DEF = 4;

  typedef logic [ADDR_W_DEF-1:0] reg_idx_t;

  // Highest architectural index; it maps to an external value, not storage.
  function automatic int unsigned top_idx(input int unsigned addr_w);
    return (32'd1 << addr_w) - 32'd1;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: tracks in-flight producers, raises stall and counts busy entries.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter bit          BYPASS = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wa,
  input  logic              flush,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned       NIDX = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(top_idx(ADDR_W));

  logic [NIDX-1:0] busy_q, busy_d;
  logic [ADDR_W:0] cnt_q, cnt_d;
  logic            fwd1, fwd2;

  // A same-cycle write-back resolves the hazard, so the source is not busy.
  assign fwd1     = BYPASS && we3 && (wa3 == ra1);
  assign fwd2     = BYPASS && we3 && (wa3 == ra2);
  assign rd1_busy = busy_q[ra1] & ~fwd1;
  assign rd2_busy = busy_q[ra2] & ~fwd2;
  assign stall    = iss_en & (rd1_busy | rd2_busy | busy_q[iss_wa]);
  assign busy_cnt = cnt_q;

  always_comb begin
    busy_d = busy_q;
    if (we3) busy_d[wa3] = 1'b0;
    if (iss_en && !stall) busy_d[iss_wa] = 1'b1;
    busy_d[TOP] = 1'b0;
    if (flush) busy_d = '0;
    cnt_d = '0;
    for (int unsigned i = 0; i < NIDX; i++) begin
      cnt_d = cnt_d + (ADDR_W+1)'(busy_d[i]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      busy_q <= '0;
      cnt_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Two-read/one-write register file with externally supplied top index and issue scoreboard.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter int unsigned BYPASS = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic              we3,
  input  logic [ADDR_W-1:0] wa3,
  input  logic [DATA_W-1:0] wd3,
  input  logic [DATA_W-1:0] r15,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_wa,
  input  logic              flush,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rd1_busy,
  output logic              rd2_busy,
  output logic              stall,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int unsigned       NIDX = 32'd1 << ADDR_W;
  localparam logic [ADDR_W-1:0] TOP  = ADDR_W'(top_idx(ADDR_W));
  localparam bit                BYP  = (BYPASS != 0);

  logic [DATA_W-1:0] regs_q [NIDX-1];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NIDX - 1; i++) regs_q[i] <= '0;
    end else if (we3 && (wa3 != TOP)) begin
      regs_q[wa3] <= wd3;
    end
  end

  always_comb begin
    rd1 = '0;
    rd2 = '0;
    if (ra1 == TOP)                  rd1 = r15;
    else if (BYP && we3 && wa3 == ra1) rd1 = wd3;
    else                             rd1 = regs_q[ra1];
    if (ra2 == TOP)                  rd2 = r15;
    else if (BYP && we3 && wa3 == ra2) rd2 = wd3;
    else                             rd2 = regs_q[ra2];
  end

  regfile_scoreboard #(
    .ADDR_W (ADDR_W),
    .BYPASS (BYP)
  ) u_sb (
    .clk      (clk),
    .reset_n  (reset_n),
    .ra1      (ra1),
    .ra2      (ra2),
    .we3      (we3),
    .wa3      (wa3),
    .iss_en   (iss_en),
    .iss_wa   (iss_wa),
    .flush    (flush),
    .rd1_busy (rd1_busy),
    .rd2_busy (rd2_busy),
    .stall    (stall),
    .busy_cnt (busy_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb against an array-based reference model.
module tb_regfile_sb;
  import regfile_pkg::*;

  localparam int unsigned DW = DATA_W_DEF;

  logic          clk = 1'b0;
  logic          reset_n;
  reg_idx_t      ra1, ra2, wa3, iss_wa;
  logic          we3, iss_en, flush;
  logic [DW-1:0] wd3, r15;
  logic [DW-1:0] rd1, rd2, nb_rd1, nb_rd2;
  logic          rd1_busy, rd2_busy, stall, nb_rd1_busy, nb_rd2_busy, nb_stall;
  logic [4:0]    busy_cnt, nb_busy_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(4), .BYPASS(1)) dut (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .r15(r15), .iss_en(iss_en), .iss_wa(iss_wa), .flush(flush), .rd1(rd1), .rd2(rd2),
    .rd1_busy(rd1_busy), .rd2_busy(rd2_busy), .stall(stall), .busy_cnt(busy_cnt)
  );

  regfile_sb #(.DATA_W(DW), .ADDR_W(4), .BYPASS(0)) dut_nb (
    .clk(clk), .reset_n(reset_n), .ra1(ra1), .ra2(ra2), .we3(we3), .wa3(wa3), .wd3(wd3),
    .r15(r15), .iss_en(iss_en), .iss_wa(iss_wa), .flush(flush), .rd1(nb_rd1), .rd2(nb_rd2),
    .rd1_busy(nb_rd1_busy), .rd2_busy(nb_rd2_busy), .stall(nb_stall), .busy_cnt(nb_busy_cnt)
  );

  // Reference model: architectural registers plus a set of busy indices.
  logic [DW-1:0] m_regs [16];
  bit            m_busy [16];

  function automatic int m_cnt();
    int n = 0;
    for (int i = 0; i < 16; i++) n += int'(m_busy[i]);
    return n;
  endfunction

  function automatic logic [DW-1:0] m_rd(input reg_idx_t ra, input bit byp);
    if (ra == 4'd15) return r15;
    if (byp && we3 && wa3 == ra) return wd3;
    return m_regs[ra];
  endfunction

  function automatic bit m_rbusy(input reg_idx_t ra);
    return m_busy[ra] && !(we3 && wa3 == ra);
  endfunction

  function automatic bit m_stall();
    return iss_en && (m_rbusy(ra1) || m_rbusy(ra2) || m_busy[iss_wa]);
  endfunction

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 16; i++) begin
        m_regs[i] <= '0;
        m_busy[i] <= 1'b0;
      end
    end else begin
      if (we3 && wa3 != 4'd15) m_regs[wa3] <= wd3;
      if (we3) m_busy[wa3] <= 1'b0;
      if (iss_en && !m_stall() && iss_wa != 4'd15) m_busy[iss_wa] <= 1'b1;
      if (flush) for (int i = 0; i < 16; i++) m_busy[i] <= 1'b0;
    end
  end

  task automatic idle();
    we3 = 1'b0; iss_en = 1'b0; flush = 1'b0;
    ra1 = '0; ra2 = '0; wa3 = '0; iss_wa = '0; wd3 = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_flush();
    idle(); flush = 1'b1; tick(); idle();
  endtask

  task automatic test_reset();
    logic [DW-1:0] v;
    v = DW'($urandom);
    idle(); we3 = 1'b1; wa3 = 4'd3; wd3 = v; iss_en = 1'b1; iss_wa = 4'd3;
    tick();
    idle(); ra1 = 4'd3;
    @(negedge clk);
    checks++; if (rd1 !== v) begin errors++; $display("FAIL pre_reset_rd1: got %h exp %h", rd1, v); end
    checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL pre_reset_cnt: got %0d exp 1", busy_cnt); end
    we3 = 1'b1; wa3 = 4'd4; wd3 = ~v; iss_en = 1'b1; iss_wa = 4'd9;
    #1 reset_n = 1'b0;
    we3 = 1'b0; iss_en = 1'b1; iss_wa = 4'd3; ra1 = 4'd3; ra2 = 4'd15; r15 = 18'h00ABC;
    #1;
    checks++; if (rd1 !== '0) begin errors++; $display("FAIL reset_rd1: got %h exp 0", rd1); end
    checks++; if (rd2 !== 18'h00ABC) begin errors++; $display("FAIL reset_rd2_top: got %h exp 00abc", rd2); end
    checks++; if (busy_cnt !== 5'd0) begin errors++; $display("FAIL reset_cnt: got %0d exp 0", busy_cnt); end
    checks++; if (rd1_busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL reset_busy_stall: got %b%b exp 00", rd1_busy, stall); end
    tick();
    ra1 = 4'd4;
    #1;
    checks++; if (rd1 !== '0 || busy_cnt !== 5'd0) begin
      errors++; $display("FAIL reset_abandon: got rd1=%h cnt=%0d exp 0/0", rd1, busy_cnt); end
    reset_n = 1'b1;
    v = DW'($urandom);
    idle(); we3 = 1'b1; wa3 = 4'd2; wd3 = v; iss_en = 1'b1; iss_wa = 4'd2;
    tick();
    idle(); ra1 = 4'd2;
    @(negedge clk);
    checks++; if (rd1 !== v || busy_cnt !== 5'd1) begin
      errors++; $display("FAIL first_after_reset: got rd1=%h cnt=%0d exp %h/1", rd1, busy_cnt, v); end
    tick();
  endtask

  task automatic test_write();
    logic [DW-1:0] old;
    old = m_regs[5];
    idle(); we3 = 1'b1; wa3 = 4'd5; wd3 = 18'h12345; ra1 = 4'd5;
    @(negedge clk);
    checks++; if (rd1 !== 18'h12345) begin errors++; $display("FAIL bypass_rd1: got %h exp 12345", rd1); end
    checks++; if (nb_rd1 !== old) begin errors++; $display("FAIL nobypass_rd1: got %h exp %h", nb_rd1, old); end
    tick();
    idle(); ra1 = 4'd5; ra2 = 4'd5;
    @(negedge clk);
    checks++; if (rd1 !== 18'h12345 || nb_rd2 !== 18'h12345) begin
      errors++; $display("FAIL write_after_edge: got %h/%h exp 12345", rd1, nb_rd2); end
    tick();
  endtask

  task automatic test_raw();
    logic [DW-1:0] v;
    v = DW'($urandom);
    do_flush();
    iss_en = 1'b1; iss_wa = 4'd7;
    @(negedge clk);
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL raw_first_issue: got stall=%b exp 0", stall); end
    tick();
    idle(); iss_en = 1'b1; iss_wa = 4'd8; ra1 = 4'd7;
    @(negedge clk);
    checks++; if (rd1_busy !== 1'b1 || stall !== 1'b1) begin
      errors++; $display("FAIL raw_stall: got busy=%b stall=%b exp 1/1", rd1_busy, stall); end
    tick();
    we3 = 1'b1; wa3 = 4'd7; wd3 = v;
    @(negedge clk);
    checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL raw_cnt_hold: got %0d exp 1", busy_cnt); end
    checks++; if (rd1_busy !== 1'b0 || stall !== 1'b0 || rd1 !== v) begin
      errors++; $display("FAIL raw_writeback: got busy=%b stall=%b rd1=%h exp 0/0/%h", rd1_busy, stall, rd1, v); end
    tick();
    idle(); ra1 = 4'd8; ra2 = 4'd7;
    @(negedge clk);
    checks++; if (busy_cnt !== 5'd1 || rd1_busy !== 1'b1 || rd2_busy !== 1'b0) begin
      errors++; $display("FAIL raw_after: got cnt=%0d b1=%b b2=%b exp 1/1/0", busy_cnt, rd1_busy, rd2_busy); end
    tick();
  endtask

  task automatic test_same_idx();
    do_flush();
    iss_en = 1'b1; iss_wa = 4'd4; we3 = 1'b1; wa3 = 4'd4; wd3 = DW'($urandom);
    tick();
    idle(); iss_en = 1'b1; iss_wa = 4'd4;
    @(negedge clk);
    checks++; if (busy_cnt !== 5'd1) begin errors++; $display("FAIL same_idx_cnt: got %0d exp 1", busy_cnt); end
    checks++; if (stall !== 1'b1) begin errors++; $display("FAIL same_idx_waw: got stall=%b exp 1", stall); end
    tick();
  endtask

  task automatic test_flush();
    logic [DW-1:0] v;
    v = DW'($urandom);
    do_flush();
    for (int k = 1; k <= 3; k++) begin
      iss_en = 1'b1; iss_wa = reg_idx_t'(k);
      tick();
    end
    idle();
    @(negedge clk);
    checks++; if (busy_cnt !== 5'd3) begin errors++; $display("FAIL flush_pre_cnt: got %0d exp 3", busy_cnt); end
    flush = 1'b1; iss_en = 1'b1; iss_wa = 4'd6; we3 = 1'b1; wa3 = 4'd9; wd3 = v;
    tick();
    idle(); iss_en = 1'b1; iss_wa = 4'd6; ra1 = 4'd9; ra2 = 4'd6;
    @(negedge clk);
    checks++; if (busy_cnt !== 5'd0) begin errors++; $display("FAIL flush_cnt: got %0d exp 0", busy_cnt); end
    checks++; if (rd2_busy !== 1'b0 || stall !== 1'b0) begin
      errors++; $display("FAIL flush_reg6: got busy=%b stall=%b exp 0/0", rd2_busy, stall); end
    checks++; if (rd1 !== v) begin errors++; $display("FAIL flush_write: got %h exp %h", rd1, v); end
    tick();
    idle();
  endtask

  task automatic test_top();
    logic [DW-1:0] old14;
    do_flush();
    old14 = m_regs[14];
    r15 = DW'($urandom);
    we3 = 1'b1; wa3 = 4'd15; wd3 = 18'h3FFFF; ra1 = 4'd15; ra2 = 4'd14;
    @(negedge clk);
    checks++; if (rd1 !== r15 || nb_rd1 !== r15) begin
      errors++; $display("FAIL top_read_wr: got %h/%h exp %h", rd1, nb_rd1, r15); end
    tick();
    idle(); iss_en = 1'b1; iss_wa = 4'd15; ra1 = 4'd15; ra2 = 4'd14;
    @(negedge clk);
    checks++; if (rd1 !== r15 || rd2 !== old14) begin
      errors++; $display("FAIL top_no_store: got %h/%h exp %h/%h", rd1, rd2, r15, old14); end
    checks++; if (stall !== 1'b0) begin errors++; $display("FAIL top_issue1: got stall=%b exp 0", stall); end
    tick();
    @(negedge clk);
    checks++; if (stall !== 1'b0 || rd1_busy !== 1'b0 || busy_cnt !== 5'd0) begin
      errors++; $display("FAIL top_issue2: got stall=%b busy=%b cnt=%0d exp 0/0/0", stall, rd1_busy, busy_cnt); end
    tick();
    idle();
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      we3 = 1'($urandom); wa3 = 4'($urandom); wd3 = DW'($urandom);
      iss_en = ($urandom_range(0, 9) < 6); iss_wa = 4'($urandom);
      ra1 = 4'($urandom); ra2 = 4'($urandom); r15 = DW'($urandom);
      flush = ($urandom_range(0, 19) == 0);
      @(negedge clk);
      checks++; if (rd1 !== m_rd(ra1, 1'b1) || rd2 !== m_rd(ra2, 1'b1)) begin
        errors++; $display("FAIL rand_rd: got %h/%h exp %h/%h", rd1, rd2, m_rd(ra1, 1'b1), m_rd(ra2, 1'b1)); end
      checks++; if (nb_rd1 !== m_rd(ra1, 1'b0) || nb_rd2 !== m_rd(ra2, 1'b0)) begin
        errors++; $display("FAIL rand_nb_rd: got %h/%h exp %h/%h", nb_rd1, nb_rd2, m_rd(ra1, 1'b0), m_rd(ra2, 1'b0)); end
      checks++; if (rd1_busy !== m_rbusy(ra1) || rd2_busy !== m_rbusy(ra2) || stall !== m_stall()) begin
        errors++; $display("FAIL rand_busy: got %b%b%b exp %b%b%b", rd1_busy, rd2_busy, stall,
                           m_rbusy(ra1), m_rbusy(ra2), m_stall()); end
      checks++; if (busy_cnt !== 5'(m_cnt())) begin
        errors++; $display("FAIL rand_cnt: got %0d exp %0d", busy_cnt, m_cnt()); end
      tick();
    end
    idle();
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    idle();
    r15 = '0;
    reset_n = 1'b1;
    #2 reset_n = 1'b0;
    #10;
    @(posedge clk);
    #1 reset_n = 1'b1;
    test_reset();
    test_write();
    test_raw();
    test_same_idx();
    test_flush();
    test_top();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
